// File: rtl/iobus_defs_pkg.sv
// Shared definitions for PDP-6 IO-bus slave devices: word/select widths,
// CONI status bit positions and the output-device FSM encoding.
package iobus_defs;

  localparam int WORD_W    = 36;
  localparam int IOS_W     = 7;
  localparam int PI_CHAN_W = 3;

  // Status bit positions, PDP-6 numbering (bit 0 = MSB)
  localparam int ST_PIA_LO = 33;
  localparam int ST_PIA_HI = 35;
  localparam int ST_DONE   = 32;
  localparam int ST_BUSY   = 31;
  localparam int ST_OVR    = 30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_OFFER = 2'd2
  } state_t;

  function automatic logic [0:WORD_W-1] status_word(
    input logic [0:PI_CHAN_W-1] pia,
    input logic                 done,
    input logic                 busy,
    input logic                 ovr
  );
    logic [0:WORD_W-1] s;
    s                      = '0;
    s[ST_PIA_LO:ST_PIA_HI] = pia;
    s[ST_DONE]             = done;
    s[ST_BUSY]             = busy;
    s[ST_OVR]              = ovr;
    return s;
  endfunction

endpackage

// File: rtl/iobus_pi_decode.sv
// Priority-interrupt channel decoder: a 3-bit PIA assignment and a request
// level become a one-hot pi_req[1:7]; PIA of zero disables the request.
module iobus_pi_decode
  import iobus_defs::*;
(
  input  logic [0:PI_CHAN_W-1] pia,
  input  logic                 req,
  output logic [1:7]           pi_req
);

  always_comb begin
    pi_req = 7'b0000000;
    for (int k = 1; k <= 7; k++) begin
      if (pia == 3'(k)) begin
        pi_req[k] = req;
      end else begin
        pi_req[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/iobus_out_dev.sv
// Generic IO-bus output device: buffers DATAO words, offers each to a
// downstream valid/ready consumer after a busy delay, then flags DONE.
module iobus_out_dev
  import iobus_defs::*;
#(
  parameter logic [IOS_W-1:0] DEVCODE = 7'o30,
  parameter int               DELAY   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iob_poweron,
  input  logic                iob_reset,
  input  logic                datao_clear,
  input  logic                datao_set,
  input  logic                cono_clear,
  input  logic                cono_set,
  input  logic                iob_fm_datai,
  input  logic                iob_fm_status,
  input  logic                rdi_pulse,
  input  logic [3:9]          ios,
  input  logic [0:WORD_W-1]   iob_write,
  output logic [1:7]          pi_req,
  output logic [0:WORD_W-1]   iob_read,
  output logic                dr_split,
  output logic                rdi_data,
  output logic [0:WORD_W-1]   out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  state_t                 r_state, w_state_nxt;
  logic [0:WORD_W-1]      r_buf, w_buf_nxt;
  logic [0:WORD_W-1]      r_word, w_word_nxt;
  logic [0:WORD_W-1]      r_outreg, w_outreg_nxt;
  logic [0:PI_CHAN_W-1]   r_pia, w_pia_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_ovr, w_ovr_nxt;
  logic [15:0]            r_cnt, w_cnt_nxt;

  logic                   w_rst, w_sel, w_abort, w_busy, w_unused;
  logic                   w_datao_clr, w_datao_set, w_cono_clr, w_cono_set;
  logic [0:WORD_W-1]      w_status;

  assign w_rst       = reset | iob_reset | ~iob_poweron;
  assign w_sel       = (ios == DEVCODE);
  assign w_datao_clr = w_sel & datao_clear;
  assign w_datao_set = w_sel & datao_set;
  assign w_cono_clr  = w_sel & cono_clear;
  assign w_cono_set  = w_sel & cono_set;
  assign w_abort     = w_cono_set & iob_write[ST_BUSY];
  assign w_busy      = (r_state != ST_IDLE);
  assign w_unused    = rdi_pulse;

  // r_word snapshots the word that started the transfer, so an overrun
  // DATAO during WAIT can refill BUF without replacing the offered word.
  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_word_nxt   = r_word;
    w_outreg_nxt = r_outreg;
    w_pia_nxt    = r_pia;
    w_done_nxt   = r_done;
    w_ovr_nxt    = r_ovr;
    w_cnt_nxt    = r_cnt;

    if (w_datao_clr) w_buf_nxt = '0;
    else             w_buf_nxt = r_buf;
    if (w_datao_set) w_buf_nxt = w_buf_nxt | iob_write;
    else             w_buf_nxt = w_buf_nxt;

    case (r_state)
      ST_IDLE: begin
        if (w_datao_set) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 16'(DELAY - 1);
          w_word_nxt  = w_buf_nxt;
          w_done_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (w_datao_set) w_ovr_nxt = 1'b1;
        else             w_ovr_nxt = r_ovr;
        if (r_cnt == 16'd0) begin
          w_outreg_nxt = r_word;
          w_state_nxt  = ST_OFFER;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_OFFER: begin
        if (w_datao_set) w_ovr_nxt = 1'b1;
        else             w_ovr_nxt = r_ovr;
        if (out_ready && !w_abort) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_OFFER;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 16'd0;
    end else begin
      w_cnt_nxt   = w_cnt_nxt;
    end

    if (w_cono_clr) begin
      w_pia_nxt  = 3'b000;
      w_done_nxt = 1'b0;
      w_ovr_nxt  = 1'b0;
    end else begin
      w_pia_nxt  = w_pia_nxt;
    end

    if (w_cono_set) begin
      w_pia_nxt = w_pia_nxt | iob_write[ST_PIA_LO:ST_PIA_HI];
      if (iob_write[ST_DONE]) w_done_nxt = 1'b1;
      else                    w_done_nxt = w_done_nxt;
    end else begin
      w_pia_nxt = w_pia_nxt;
    end
  end

  // State and data registers; bus reset and power loss act like reset.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state  <= ST_IDLE;
      r_buf    <= '0;
      r_word   <= '0;
      r_outreg <= '0;
      r_pia    <= 3'b000;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      r_cnt    <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_buf    <= w_buf_nxt;
      r_word   <= w_word_nxt;
      r_outreg <= w_outreg_nxt;
      r_pia    <= w_pia_nxt;
      r_done   <= w_done_nxt;
      r_ovr    <= w_ovr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign w_status = status_word(r_pia, r_done, w_busy, r_ovr);

  assign iob_read  = ({WORD_W{w_sel & iob_fm_datai}}  & r_buf) |
                     ({WORD_W{w_sel & iob_fm_status}} & w_status);
  assign out_valid = (r_state == ST_OFFER);
  assign out_data  = r_outreg;
  assign dr_split  = 1'b0;
  assign rdi_data  = 1'b0;

  iobus_pi_decode u_pi_decode (
    .pia    (r_pia),
    .req    (r_done),
    .pi_req (pi_req)
  );

endmodule

// File: tb/tb_iobus_out_dev.sv
// Directed self-checking bench for iobus_out_dev (DEVCODE 7'o30, DELAY 16).
module tb_iobus_out_dev;

  localparam logic [6:0] CODE  = 7'o30;
  localparam logic [6:0] OTHER = 7'o31;

  logic        clk = 1'b0;
  logic        reset, iob_poweron, iob_reset;
  logic        datao_clear, datao_set, cono_clear, cono_set;
  logic        iob_fm_datai, iob_fm_status, rdi_pulse;
  logic [3:9]  ios;
  logic [0:35] iob_write;
  logic [1:7]  pi_req;
  logic [0:35] iob_read;
  logic        dr_split, rdi_data;
  logic [0:35] out_data;
  logic        out_valid, out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iobus_out_dev #(.DEVCODE(7'o30), .DELAY(16)) dut (
    .clk(clk), .reset(reset), .iob_poweron(iob_poweron), .iob_reset(iob_reset),
    .datao_clear(datao_clear), .datao_set(datao_set),
    .cono_clear(cono_clear), .cono_set(cono_set),
    .iob_fm_datai(iob_fm_datai), .iob_fm_status(iob_fm_status),
    .rdi_pulse(rdi_pulse), .ios(ios), .iob_write(iob_write),
    .pi_req(pi_req), .iob_read(iob_read), .dr_split(dr_split),
    .rdi_data(rdi_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_datao(input logic [6:0] code, input logic [0:35] w, input logic clr);
    ios = code; iob_write = w; datao_clear = clr; datao_set = 1'b1;
    step();
    datao_clear = 1'b0; datao_set = 1'b0; iob_write = 36'o0; ios = CODE;
  endtask

  task automatic do_cono(input logic [0:35] w, input logic clr);
    ios = CODE; iob_write = w; cono_clear = clr; cono_set = 1'b1;
    step();
    cono_clear = 1'b0; cono_set = 1'b0; iob_write = 36'o0;
  endtask

  task automatic rd(input logic [6:0] code, input logic status, output logic [0:35] v);
    ios = code; iob_fm_status = status; iob_fm_datai = ~status;
    #1;
    v = iob_read;
    iob_fm_status = 1'b0; iob_fm_datai = 1'b0; ios = CODE;
  endtask

  task automatic test_reset();
    logic [0:35] v;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o0) begin failures++; $display("FAIL reset_coni got %o exp %o", v, 36'o0); end
    checks++; if (pi_req !== 7'b0000000) begin failures++; $display("FAIL reset_pi_req got %b exp 0000000", pi_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (dr_split !== 1'b0 || rdi_data !== 1'b0) begin failures++; $display("FAIL tied_outputs got %b%b exp 00", dr_split, rdi_data); end
  endtask

  task automatic test_transfer();
    logic [0:35] v;
    do_cono(36'o5, 1'b0);
    out_ready = 1'b1;
    do_datao(CODE, 36'o123456701234, 1'b1);
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o25) begin failures++; $display("FAIL busy_coni got %o exp %o", v, 36'o25); end
    for (int n = 2; n <= 16; n++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL early_valid cycle %0d got %b exp 0", n, out_valid); end
    end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL valid_at_17 got %b exp 1", out_valid); end
    checks++; if (out_data !== 36'o123456701234) begin failures++; $display("FAIL out_data got %o exp %o", out_data, 36'o123456701234); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL valid_after_accept got %b exp 0", out_valid); end
    checks++; if (pi_req !== 7'b0000100) begin failures++; $display("FAIL pi_req_ch5 got %b exp 0000100", pi_req); end
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o15) begin failures++; $display("FAIL done_coni got %o exp %o", v, 36'o15); end
    rd(CODE, 1'b0, v);
    checks++; if (v !== 36'o123456701234) begin failures++; $display("FAIL datai got %o exp %o", v, 36'o123456701234); end
    out_ready = 1'b0;
  endtask

  task automatic test_unselected();
    logic [0:35] v;
    rd(OTHER, 1'b0, v);
    checks++; if (v !== 36'o0) begin failures++; $display("FAIL other_datai got %o exp 0", v); end
    rd(OTHER, 1'b1, v);
    checks++; if (v !== 36'o0) begin failures++; $display("FAIL other_coni got %o exp 0", v); end
    do_datao(OTHER, 36'o55, 1'b1);
    rd(CODE, 1'b0, v);
    checks++; if (v !== 36'o123456701234) begin failures++; $display("FAIL other_datao_buf got %o exp %o", v, 36'o123456701234); end
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o15) begin failures++; $display("FAIL other_datao_coni got %o exp %o", v, 36'o15); end
  endtask

  task automatic test_overrun();
    logic [0:35] v;
    out_ready = 1'b0;
    do_datao(CODE, 36'o1111, 1'b1);
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o25) begin failures++; $display("FAIL ovr_start_coni got %o exp %o", v, 36'o25); end
    step(); step(); step();
    do_datao(CODE, 36'o777, 1'b1);
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o65) begin failures++; $display("FAIL ovr_coni got %o exp %o", v, 36'o65); end
    rd(CODE, 1'b0, v);
    checks++; if (v !== 36'o777) begin failures++; $display("FAIL ovr_buf got %o exp %o", v, 36'o777); end
    for (int n = 1; n <= 12; n++) begin
      step();
      checks++; if (out_valid !== (n == 12)) begin failures++; $display("FAIL ovr_valid step %0d got %b exp %b", n, out_valid, (n == 12)); end
    end
    checks++; if (out_data !== 36'o1111) begin failures++; $display("FAIL ovr_out_data got %o exp %o", out_data, 36'o1111); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_accept_valid got %b exp 0", out_valid); end
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o55) begin failures++; $display("FAIL ovr_done_coni got %o exp %o", v, 36'o55); end
    for (int n = 0; n < 20; n++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL second_transfer step %0d got %b exp 0", n, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic [0:35] v;
    do_cono(36'o5, 1'b1);
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o5) begin failures++; $display("FAIL cono_clr_set got %o exp %o", v, 36'o5); end
    do_datao(CODE, 36'o42, 1'b1);
    rd(CODE, 1'b0, v);
    checks++; if (v !== 36'o42) begin failures++; $display("FAIL datao_clr_set got %o exp %o", v, 36'o42); end
    for (int n = 2; n <= 17; n++) step();
    for (int n = 0; n < 50; n++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 36'o42) begin failures++; $display("FAIL hold_offer step %0d got %b/%o exp 1/%o", n, out_valid, out_data, 36'o42); end
      step();
    end
    out_ready = 1'b1;
    do_cono(36'o20, 1'b0);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got %b exp 0", out_valid); end
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o5) begin failures++; $display("FAIL abort_coni got %o exp %o", v, 36'o5); end
    checks++; if (pi_req !== 7'b0000000) begin failures++; $display("FAIL abort_pi_req got %b exp 0000000", pi_req); end
  endtask

  task automatic test_bus_reset();
    logic [0:35] v;
    int n;
    do_datao(CODE, 36'o7, 1'b1);
    for (int k = 2; k <= 17; k++) step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got %b exp 1", out_valid); end
    iob_reset = 1'b1;
    step();
    iob_reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 36'o0) begin failures++; $display("FAIL iob_reset_out got %b/%o exp 0/0", out_valid, out_data); end
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o0) begin failures++; $display("FAIL iob_reset_coni got %o exp 0", v); end
    rd(CODE, 1'b0, v);
    checks++; if (v !== 36'o0) begin failures++; $display("FAIL iob_reset_buf got %o exp 0", v); end
    checks++; if (pi_req !== 7'b0000000) begin failures++; $display("FAIL iob_reset_pi got %b exp 0000000", pi_req); end
    do_cono(36'o3, 1'b0);
    out_ready = 1'b1;
    do_datao(CODE, 36'o70, 1'b1);
    n = 1;
    while (n < 40) begin
      n++;
      step();
      if (out_valid) break;
    end
    checks++; if (n !== 17) begin failures++; $display("FAIL post_reset_latency got %0d exp 17", n); end
    checks++; if (out_data !== 36'o70) begin failures++; $display("FAIL post_reset_data got %o exp %o", out_data, 36'o70); end
    step();
    out_ready = 1'b0;
    checks++; if (pi_req !== 7'b0010000) begin failures++; $display("FAIL pi_req_ch3 got %b exp 0010000", pi_req); end
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o13) begin failures++; $display("FAIL post_reset_coni got %o exp %o", v, 36'o13); end
    iob_poweron = 1'b0;
    step();
    iob_poweron = 1'b1;
    checks++; if (pi_req !== 7'b0000000) begin failures++; $display("FAIL poweroff_pi got %b exp 0000000", pi_req); end
    rd(CODE, 1'b1, v);
    checks++; if (v !== 36'o0) begin failures++; $display("FAIL poweroff_coni got %o exp 0", v); end
  endtask

  initial begin
    reset = 1'b1; iob_poweron = 1'b1; iob_reset = 1'b0;
    datao_clear = 1'b0; datao_set = 1'b0; cono_clear = 1'b0; cono_set = 1'b0;
    iob_fm_datai = 1'b0; iob_fm_status = 1'b0; rdi_pulse = 1'b0;
    ios = CODE; iob_write = 36'o0; out_ready = 1'b0;
    test_reset();
    test_transfer();
    test_unselected();
    test_overrun();
    test_abort();
    test_bus_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
